// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } mult_state_e;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle for the shift-and-add multiplier; the master side
// issues operands and Start, the slave side returns status and Product.
interface shift_add_multiplier_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);

    logic               Start;
    logic               Signed_En;
    logic [WIDTH-1:0]   Multiplicand;
    logic [WIDTH-1:0]   Multiplier;
    logic               Busy;
    logic               Done;
    logic [2*WIDTH-1:0] Product;
    logic               X;

    modport master (
        output Start, Signed_En, Multiplicand, Multiplier,
        input  Busy, Done, Product, X
    );

    modport slave (
        input  Start, Signed_En, Multiplicand, Multiplier,
        output Busy, Done, Product, X
    );

endinterface

// File: rtl/add_sub_n.sv
// N-bit combinational adder/subtractor (two's-complement subtract via invert
// and carry-in); the top result bit is the sign (signed) or carry (unsigned).
module add_sub_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-2:0] sum,
    output logic         sign_carry
);

    logic [N-1:0] b_eff;
    logic [N-1:0] result;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value on every
        // path (here unconditionally), otherwise a latch is inferred.
        b_eff  = sub ? ~b : b;
        result = a + b_eff + {{(N-1){1'b0}}, sub};
    end

    assign sum        = result[N-2:0];
    assign sign_carry = result[N-1];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock over an
// X:A:B register chain, signed (subtract on the sign bit) or unsigned.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Signed_En,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product,
    output logic               X
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;
    localparam logic [1:0] HOLD = ST_HOLD;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             x_q;
    logic             signed_q;

    logic             load;
    logic             do_sub;
    logic [WIDTH:0]   acc_op, s_ext;
    logic [WIDTH-1:0] sum_lo;
    logic             sum_msb;
    logic             pre_x;
    logic [WIDTH-1:0] pre_a;
    logic             x_next;
    logic [WIDTH-1:0] a_next, b_next;

    assign load = (state_q == IDLE) && Start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = Start ? HOLD : IDLE;
            HOLD:    if (!Start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The sign bit of B carries negative weight, so its partial product is
    // subtracted in signed mode.
    assign do_sub = signed_q && (cnt_q == LAST);
    assign acc_op = {x_q, a_q};
    assign s_ext  = {signed_q & s_q[WIDTH-1], s_q};

    add_sub_n #(.N(WIDTH + 1)) u_add_sub (
        .a          (acc_op),
        .b          (s_ext),
        .sub        (do_sub),
        .sum        (sum_lo),
        .sign_carry (sum_msb)
    );

    assign pre_x = b_q[0] ? sum_msb : x_q;
    assign pre_a = b_q[0] ? sum_lo  : a_q;

    // Signed: arithmetic shift keeps X. Unsigned: X (the carry) drops into A
    // and X clears, which is a logical shift of the full chain.
    assign x_next = signed_q ? pre_x : 1'b0;
    assign a_next = {pre_x, pre_a[WIDTH-1:1]};
    assign b_next = {pre_a[0], b_q[WIDTH-1:1]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: the datapath registers are reset too, because the
            // Product and X outputs are driven straight from them.
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            x_q      <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q <= state_d;
            if (load) begin
                cnt_q    <= '0;
                a_q      <= '0;
                b_q      <= Multiplier;
                s_q      <= Multiplicand;
                x_q      <= 1'b0;
                signed_q <= Signed_En;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                a_q   <= a_next;
                b_q   <= b_next;
                x_q   <= x_next;
            end
        end
    end

    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == DONE);
    assign Product = {a_q, b_q};
    assign X       = x_q;

endmodule
